// File: rtl/qdrc_pkg.sv
// Shared QDR-II constants, FSM state types and lane helper used by the SRAM emulator and PHY calibration.
// No timing of its own.
package qdrc_pkg;

  localparam int QDRC_BURST_WORDS     = 4;
  localparam int QDRC_DEFAULT_LATENCY = 11;

  typedef enum logic {WR_IDLE, WR_BEAT1} wr_state_t;
  typedef enum logic {RD_IDLE, RD_BEAT1} rd_state_t;

  function automatic int qdrc_lane_width(input int data_width, input int bw_width);
    return data_width / bw_width;
  endfunction

endpackage

// File: rtl/qdrc_sram_emu_delay.sv
// Fixed-depth shift register with a valid bit; latency DEPTH cycles, no backpressure.
// Reset clears only the valid bits so payload flops stay reset-free.
module qdrc_sram_emu_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  logic [DEPTH-1:0] vld_sr;
  logic [WIDTH-1:0] dat_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dat_sr[0] <= in_dat;
    for (int i = 1; i < DEPTH; i++) dat_sr[i] <= dat_sr[i-1];
  end

  assign out_vld = vld_sr[DEPTH-1];
  assign out_dat = dat_sr[DEPTH-1];

endmodule

// File: rtl/qdrc_sram_emu.sv
// QDR-II burst-of-4 SRAM responder for PHY loopback; read beats at READ_LATENCY (+1 on skewed bits).
// No backpressure: commands closer than 2 cycles per type are dropped and flagged on proto_err.
module qdrc_sram_emu
  import qdrc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 36,
  parameter int                    BW_WIDTH     = 4,
  parameter int                    ADDR_WIDTH   = 21,
  parameter int                    DEPTH_BITS   = 6,
  parameter int                    READ_LATENCY = QDRC_DEFAULT_LATENCY,
  parameter logic [DATA_WIDTH-1:0] SKEW_MASK    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  qdr_w_n,
  input  logic                  qdr_r_n,
  input  logic [ADDR_WIDTH-1:0] qdr_sa,
  input  logic [DATA_WIDTH-1:0] qdr_d_rise,
  input  logic [DATA_WIDTH-1:0] qdr_d_fall,
  input  logic [BW_WIDTH-1:0]   qdr_bw_n_rise,
  input  logic [BW_WIDTH-1:0]   qdr_bw_n_fall,
  output logic [DATA_WIDTH-1:0] qdr_q_rise,
  output logic [DATA_WIDTH-1:0] qdr_q_fall,
  output logic                  qdr_q_valid,
  output logic                  proto_err
);

  localparam int LANE_W    = qdrc_lane_width(DATA_WIDTH, BW_WIDTH);
  localparam int MEM_DEPTH = 1 << DEPTH_BITS;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] b0_rise;
    logic [DATA_WIDTH-1:0] b0_fall;
    logic [DATA_WIDTH-1:0] b1_rise;
    logic [DATA_WIDTH-1:0] b1_fall;
  } burst_t;

  burst_t                mem [MEM_DEPTH];
  wr_state_t             wr_state, wr_state_nxt;
  rd_state_t             rd_state, rd_state_nxt;
  logic                  wr_pend;
  logic [DEPTH_BITS-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_b0_rise, wr_b0_fall;
  logic [BW_WIDTH-1:0]   wr_bw0_rise, wr_bw0_fall;
  logic                  wr_accept, wr_drop, wr_commit, rd_accept, rd_drop;
  burst_t                wr_old, wr_merged, rd_burst, lat_dat;
  logic                  lat_vld, b1_vld, sk_vld;
  logic [DATA_WIDTH-1:0] b1_rise, b1_fall, q_rise_u, q_fall_u, sk_rise, sk_fall;
  logic [2*DATA_WIDTH-1:0] sk_dat;
  logic                  unused_sa_hi;

  // Upper address bits alias onto the implemented locations.
  if (ADDR_WIDTH > DEPTH_BITS) begin : g_sa_hi
    assign unused_sa_hi = ^qdr_sa[ADDR_WIDTH-1:DEPTH_BITS];
  end else begin : g_sa_none
    assign unused_sa_hi = 1'b0;
  end

  function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [BW_WIDTH-1:0]   bw_n);
    lane_merge = old_w;
    for (int k = 0; k < BW_WIDTH; k++)
      if (!bw_n[k]) lane_merge[k*LANE_W +: LANE_W] = new_w[k*LANE_W +: LANE_W];
  endfunction

  always_comb begin
    wr_accept    = !qdr_w_n && !wr_pend;
    wr_drop      = !qdr_w_n && wr_pend;
    rd_accept    = !qdr_r_n && (rd_state == RD_IDLE);
    rd_drop      = !qdr_r_n && (rd_state == RD_BEAT1);
    wr_commit    = (wr_state == WR_BEAT1);
    wr_state_nxt = wr_pend ? WR_BEAT1 : WR_IDLE;
    rd_state_nxt = rd_accept ? RD_BEAT1 : RD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_state  <= WR_IDLE;
      rd_state  <= RD_IDLE;
      wr_pend   <= 1'b0;
      b1_vld    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      wr_pend  <= wr_accept;
      b1_vld   <= lat_vld;
      if (wr_drop || rd_drop) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) wr_addr <= qdr_sa[DEPTH_BITS-1:0];
    if (wr_pend) begin
      wr_b0_rise  <= qdr_d_rise;
      wr_b0_fall  <= qdr_d_fall;
      wr_bw0_rise <= qdr_bw_n_rise;
      wr_bw0_fall <= qdr_bw_n_fall;
    end
    if (reset_n && wr_commit) mem[wr_addr] <= wr_merged;
    b1_rise <= lat_dat.b1_rise;
    b1_fall <= lat_dat.b1_fall;
  end

  // Beat1 is merged straight from the pins in the commit cycle.
  assign wr_old = mem[wr_addr];
  always_comb begin
    wr_merged.b0_rise = lane_merge(wr_old.b0_rise, wr_b0_rise, wr_bw0_rise);
    wr_merged.b0_fall = lane_merge(wr_old.b0_fall, wr_b0_fall, wr_bw0_fall);
    wr_merged.b1_rise = lane_merge(wr_old.b1_rise, qdr_d_rise, qdr_bw_n_rise);
    wr_merged.b1_fall = lane_merge(wr_old.b1_fall, qdr_d_fall, qdr_bw_n_fall);
  end

  assign rd_burst = mem[qdr_sa[DEPTH_BITS-1:0]];

  qdrc_sram_emu_delay #(
    .WIDTH(QDRC_BURST_WORDS*DATA_WIDTH),
    .DEPTH(READ_LATENCY)
  ) u_lat (
    .clk    (clk),
    .reset_n(reset_n),
    .in_vld (rd_accept),
    .in_dat (rd_burst),
    .out_vld(lat_vld),
    .out_dat(lat_dat)
  );

  always_comb begin
    q_rise_u = '0;
    q_fall_u = '0;
    if (lat_vld) begin
      q_rise_u = lat_dat.b0_rise;
      q_fall_u = lat_dat.b0_fall;
    end else if (b1_vld) begin
      q_rise_u = b1_rise;
      q_fall_u = b1_fall;
    end
  end

  assign qdr_q_valid = lat_vld | b1_vld;

  qdrc_sram_emu_delay #(
    .WIDTH(2*DATA_WIDTH),
    .DEPTH(1)
  ) u_skew (
    .clk    (clk),
    .reset_n(reset_n),
    .in_vld (qdr_q_valid),
    .in_dat ({q_rise_u, q_fall_u}),
    .out_vld(sk_vld),
    .out_dat(sk_dat)
  );

  // Gating by the delayed valid reproduces the delayed 0/data stream exactly.
  assign sk_rise    = sk_vld ? sk_dat[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign sk_fall    = sk_vld ? sk_dat[DATA_WIDTH-1:0] : '0;
  assign qdr_q_rise = (q_rise_u & ~SKEW_MASK) | (sk_rise & SKEW_MASK);
  assign qdr_q_fall = (q_fall_u & ~SKEW_MASK) | (sk_fall & SKEW_MASK);

endmodule
